// File: rtl/sd_pkg.sv
// Shared constants and state encoding for the SD sector buffer.
package sd_pkg;
  localparam int SD_SECTOR_BYTES            = 512;
  localparam int SD_ADDR_W                  = 9;
  localparam int SD_TIMEOUT_CYCLES_DEFAULT  = 25000000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_FILL     = 2'd2
  } sd_state_t;
endpackage

// File: rtl/sd_sector_buffer_if.sv
// Bus-side and SD-controller-side signals of the sector buffer, plus FSM debug taps.
interface sd_sector_buffer_if;
  import sd_pkg::*;

  logic        cmd_addr_we;
  logic [31:0] cmd_addr;
  logic        cmd_start;
  logic        buf_re;
  logic [8:0]  buf_index;
  logic [7:0]  buf_rdata;
  logic        buf_rvalid;
  logic        avail;
  logic        busy;
  logic        timeout;
  logic        sd_ready;
  logic        sd_byte_available;
  logic [7:0]  sd_dout;
  logic        sd_rd;
  logic [31:0] sd_address;
  sd_state_t   state_dbg;
  logic [9:0]  byte_cnt_dbg;

  // Handshakes: sd_rd is a single-cycle request accepted only while sd_ready is high;
  // a byte is transferred on each 0->1 edge of the sd_byte_available level; buf_rvalid
  // pulses exactly one cycle after each buf_re and carries no backpressure.
  modport master (
    output cmd_addr_we, cmd_addr, cmd_start, buf_re, buf_index,
           sd_ready, sd_byte_available, sd_dout,
    input  buf_rdata, buf_rvalid, avail, busy, timeout, sd_rd, sd_address,
           state_dbg, byte_cnt_dbg
  );

  modport slave (
    input  cmd_addr_we, cmd_addr, cmd_start, buf_re, buf_index,
           sd_ready, sd_byte_available, sd_dout,
    output buf_rdata, buf_rvalid, avail, busy, timeout, sd_rd, sd_address,
           state_dbg, byte_cnt_dbg
  );
endinterface

// File: rtl/sector_ram.sv
// 512x8 simple dual-port RAM: one write port, one registered read port.
module sector_ram
  import sd_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [SD_ADDR_W-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic                 re,
  input  logic [SD_ADDR_W-1:0] raddr,
  output logic [7:0]           rdata
);
  logic [7:0] mem [SD_SECTOR_BYTES];

  // Contents survive reset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register only updates on re, so data holds between reads and a
  // same-address write in the same cycle returns the old byte.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sd_sector_buffer.sv
// Reads one 512-byte sector from an SD controller into a local buffer readable by the bus.
module sd_sector_buffer
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = SD_TIMEOUT_CYCLES_DEFAULT
) (
  input logic               clk,
  input logic               reset,
  sd_sector_buffer_if.slave bus
);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]  LAST_BYTE = 10'(SD_SECTOR_BYTES - 1);

  sd_state_t   state_q, state_d;
  logic [9:0]  byte_cnt_q;
  logic [31:0] tmo_cnt_q;
  logic        avail_edge_q;
  logic        byte_evt, go_start, issue_rd, byte_wr, sector_done, tmo_hit;

  assign byte_evt         = bus.sd_byte_available & ~avail_edge_q;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.state_dbg    = state_q;
  assign bus.byte_cnt_dbg = byte_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    go_start    = 1'b0;
    issue_rd    = 1'b0;
    byte_wr     = 1'b0;
    sector_done = 1'b0;
    tmo_hit     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_start) begin
          go_start = 1'b1;
          state_d  = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: begin
        if (bus.sd_ready) begin
          issue_rd = 1'b1;
          state_d  = ST_FILL;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        // A byte event wins over an expiring timeout in the same cycle.
        if (byte_evt) begin
          byte_wr = 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            sector_done = 1'b1;
            state_d     = ST_IDLE;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avail_edge_q   <= 1'b0;
      bus.sd_rd      <= 1'b0;
      bus.buf_rvalid <= 1'b0;
      bus.sd_address <= '0;
      bus.avail      <= 1'b0;
      bus.timeout    <= 1'b0;
      byte_cnt_q     <= '0;
      tmo_cnt_q      <= '0;
    end else begin
      avail_edge_q   <= bus.sd_byte_available;
      bus.sd_rd      <= issue_rd;
      bus.buf_rvalid <= bus.buf_re;
      if (state_q == ST_IDLE && bus.cmd_addr_we) bus.sd_address <= bus.cmd_addr;

      if (go_start) begin
        bus.avail   <= 1'b0;
        bus.timeout <= 1'b0;
        byte_cnt_q  <= '0;
        tmo_cnt_q   <= '0;
      end else if (byte_wr) begin
        tmo_cnt_q  <= '0;
        byte_cnt_q <= sector_done ? 10'd0 : byte_cnt_q + 10'd1;
        if (sector_done) bus.avail <= 1'b1;
      end else if (tmo_hit) begin
        bus.timeout <= 1'b1;
        tmo_cnt_q   <= '0;
        byte_cnt_q  <= '0;
      end else if (state_q != ST_IDLE) begin
        tmo_cnt_q <= tmo_cnt_q + 32'd1;
      end
    end
  end

  sector_ram u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (byte_wr),
    .waddr (byte_cnt_q[SD_ADDR_W-1:0]),
    .wdata (bus.sd_dout),
    .re    (bus.buf_re),
    .raddr (bus.buf_index),
    .rdata (bus.buf_rdata)
  );
endmodule

// File: tb/tb_sd_sector_buffer.sv
// Scenario bench for sd_sector_buffer: main instance plus a short-timeout instance.
module tb_sd_sector_buffer;
  import sd_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sd_sector_buffer_if bif ();
  sd_sector_buffer_if tif ();

  sd_sector_buffer #(.TIMEOUT_CYCLES(4000)) dut (.clk(clk), .reset(reset), .bus(bif));
  sd_sector_buffer #(.TIMEOUT_CYCLES(64))   dut_t (.clk(clk), .reset(reset), .bus(tif));

  int total = 0;
  int bad   = 0;
  logic [7:0] model_mem [512];
  int model_cnt = 0;
  logic [7:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bif.cmd_addr_we = 0; bif.cmd_addr = '0; bif.cmd_start = 0; bif.buf_re = 0;
    bif.buf_index = '0; bif.sd_ready = 0; bif.sd_byte_available = 0; bif.sd_dout = '0;
    tif.cmd_addr_we = 0; tif.cmd_addr = '0; tif.cmd_start = 0; tif.buf_re = 0;
    tif.buf_index = '0; tif.sd_ready = 0; tif.sd_byte_available = 0; tif.sd_dout = '0;
  endtask

  task automatic start_read(input logic [31:0] addr);
    bif.cmd_addr = addr; bif.cmd_addr_we = 1; bif.cmd_start = 1;
    tick();
    bif.cmd_addr_we = 0; bif.cmd_start = 0;
    model_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit store);
    bif.sd_dout = v; bif.sd_byte_available = 1;
    tick();
    if (store) begin model_mem[model_cnt] = v; model_cnt++; end
    bif.sd_byte_available = 0;
    tick();
  endtask

  task automatic read_check(input logic [8:0] idx);
    logic [7:0] e;
    bif.buf_re = 1; bif.buf_index = idx;
    exp_q.push_back(model_mem[idx]);
    tick();
    bif.buf_re = 0;
    e = exp_q.pop_front();
    total++;
    if (bif.buf_rvalid !== 1'b1) begin
      bad++; $display("FAIL rvalid idx=%0d got=%b want=1", idx, bif.buf_rvalid);
    end
    total++;
    if (bif.buf_rdata !== e) begin
      bad++; $display("FAIL rdata idx=%0d got=%0h want=%0h", idx, bif.buf_rdata, e);
    end
  endtask

  task automatic count_rd(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bif.sd_rd === 1'b1) cnt++;
    end
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1;
    tick(); tick();
    total++;
    if ({bif.avail, bif.busy, bif.timeout, bif.sd_rd, bif.buf_rvalid} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b want=00000",
                      {bif.avail, bif.busy, bif.timeout, bif.sd_rd, bif.buf_rvalid});
    end
    total++;
    if (bif.sd_address !== 32'h0 || bif.buf_rdata !== 8'h0 || bif.byte_cnt_dbg !== 10'h0) begin
      bad++; $display("FAIL reset_regs got=%0h/%0h/%0h want=0/0/0",
                      bif.sd_address, bif.buf_rdata, bif.byte_cnt_dbg);
    end
    total++;
    if (bif.state_dbg !== ST_IDLE || tif.busy !== 1'b0) begin
      bad++; $display("FAIL reset_state got=%0d want=%0d", bif.state_dbg, ST_IDLE);
    end
    reset = 0;
    tick();
  endtask

  task automatic test_basic_fill();
    int n;
    bif.sd_ready = 1;
    start_read(32'h0000_0010);
    total++;
    if (bif.sd_address !== 32'h10 || bif.busy !== 1'b1) begin
      bad++; $display("FAIL start addr/busy got=%0h/%b want=10/1", bif.sd_address, bif.busy);
    end
    count_rd(4, n);
    total++;
    if (n != 1) begin bad++; $display("FAIL rd_pulses got=%0d want=1", n); end
    bif.sd_ready = 0;
    for (int i = 0; i < 512; i++) begin
      send_byte(8'(i), 1'b1);
      if (i == 255) begin
        total++;
        if (bif.byte_cnt_dbg !== 10'd256) begin
          bad++; $display("FAIL mid_cnt got=%0d want=256", bif.byte_cnt_dbg);
        end
      end
    end
    total++;
    if (bif.avail !== 1'b1 || bif.busy !== 1'b0 || bif.timeout !== 1'b0) begin
      bad++; $display("FAIL fill_done got=%b%b%b want=100", bif.avail, bif.busy, bif.timeout);
    end
    total++;
    if (bif.byte_cnt_dbg !== 10'd0) begin
      bad++; $display("FAIL cnt_after got=%0d want=0", bif.byte_cnt_dbg);
    end
    read_check(9'd0);
    read_check(9'd255);
    read_check(9'd511);
    tick(); tick(); tick();
    total++;
    if (bif.buf_rdata !== 8'hFF || bif.buf_rvalid !== 1'b0) begin
      bad++; $display("FAIL hold got=%0h/%b want=ff/0", bif.buf_rdata, bif.buf_rvalid);
    end
  endtask

  task automatic test_ready_wait();
    int n;
    bif.sd_ready = 0;
    start_read(32'h0000_2000);
    count_rd(100, n);
    total++;
    if (n != 0 || bif.state_dbg !== ST_WAIT_RDY) begin
      bad++; $display("FAIL wait_rd got=%0d/%0d want=0/%0d", n, bif.state_dbg, ST_WAIT_RDY);
    end
    bif.sd_ready = 1;
    count_rd(10, n);
    total++;
    if (n != 1) begin bad++; $display("FAIL late_rd got=%0d want=1", n); end
    bif.sd_ready = 0;
    for (int i = 0; i < 512; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    total++;
    if (bif.avail !== 1'b1) begin bad++; $display("FAIL rnd_avail got=%b want=1", bif.avail); end
    for (int k = 0; k < 6; k++) read_check(9'($urandom_range(0, 511)));
  endtask

  task automatic test_ignore_busy();
    int n;
    bif.sd_ready = 1;
    start_read(32'h0000_1234);
    count_rd(2, n);
    bif.sd_ready = 0;
    for (int i = 0; i < 100; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    bif.cmd_addr = 32'h55; bif.cmd_addr_we = 1; bif.cmd_start = 1;
    tick();
    bif.cmd_addr_we = 0; bif.cmd_start = 0;
    total++;
    if (bif.sd_address !== 32'h1234 || bif.state_dbg !== ST_FILL || bif.byte_cnt_dbg !== 10'd100) begin
      bad++; $display("FAIL busy_ignore got=%0h/%0d/%0d want=1234/%0d/100",
                      bif.sd_address, bif.state_dbg, bif.byte_cnt_dbg, ST_FILL);
    end
    for (int i = 100; i < 512; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    total++;
    if (bif.avail !== 1'b1 || bif.sd_address !== 32'h1234) begin
      bad++; $display("FAIL busy_done got=%b/%0h want=1/1234", bif.avail, bif.sd_address);
    end
    read_check(9'd99);
    read_check(9'd100);
    read_check(9'd511);
  endtask

  task automatic test_level_hold();
    int n;
    bif.sd_ready = 1;
    start_read(32'h0000_0040);
    count_rd(2, n);
    bif.sd_ready = 0;
    bif.sd_dout = 8'h3C; bif.sd_byte_available = 1;
    tick();
    model_mem[0] = 8'h3C; model_cnt = 1;
    bif.sd_dout = 8'h99;
    for (int i = 0; i < 4; i++) tick();
    bif.sd_byte_available = 0;
    tick();
    total++;
    if (bif.byte_cnt_dbg !== 10'd1) begin
      bad++; $display("FAIL level_cnt got=%0d want=1", bif.byte_cnt_dbg);
    end
    for (int i = 1; i < 512; i++) send_byte(8'(i) ^ 8'h5A, 1'b1);
    bif.sd_dout = 8'h77; bif.sd_byte_available = 1;
    tick();
    bif.sd_byte_available = 0;
    tick();
    total++;
    if (bif.byte_cnt_dbg !== 10'd0 || bif.busy !== 1'b0 || bif.avail !== 1'b1) begin
      bad++; $display("FAIL idle_toggle got=%0d/%b/%b want=0/0/1",
                      bif.byte_cnt_dbg, bif.busy, bif.avail);
    end
    read_check(9'd0);
    read_check(9'd1);
  endtask

  task automatic test_reset_mid();
    int n;
    logic [7:0] e;
    bif.sd_ready = 1;
    start_read(32'h0000_0077);
    count_rd(2, n);
    bif.sd_ready = 0;
    for (int i = 0; i < 200; i++) send_byte(8'(i * 7 + 1), 1'b1);
    reset = 1;
    tick();
    reset = 0;
    total++;
    if ({bif.avail, bif.busy, bif.timeout, bif.sd_rd, bif.buf_rvalid} !== 5'b0 ||
        bif.sd_address !== 32'h0 || bif.buf_rdata !== 8'h0 || bif.byte_cnt_dbg !== 10'd0) begin
      bad++; $display("FAIL mid_reset got=%b/%0h/%0h/%0d want=00000/0/0/0",
                      {bif.avail, bif.busy, bif.timeout, bif.sd_rd, bif.buf_rvalid},
                      bif.sd_address, bif.buf_rdata, bif.byte_cnt_dbg);
    end
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    total++;
    if (bif.byte_cnt_dbg !== 10'd0 || bif.busy !== 1'b0 || bif.avail !== 1'b0) begin
      bad++; $display("FAIL post_reset got=%0d/%b/%b want=0/0/0",
                      bif.byte_cnt_dbg, bif.busy, bif.avail);
    end
    read_check(9'd5);
    bif.sd_ready = 1;
    start_read(32'h0000_0088);
    count_rd(2, n);
    bif.sd_ready = 0;
    for (int i = 0; i < 512; i++) begin
      if (i == 10) begin
        bif.sd_dout = 8'(i * 13 + 200); bif.sd_byte_available = 1;
        bif.buf_re = 1; bif.buf_index = 9'd10;
        exp_q.push_back(model_mem[10]);
        tick();
        model_mem[model_cnt] = 8'(i * 13 + 200); model_cnt++;
        bif.buf_re = 0; bif.sd_byte_available = 0;
        e = exp_q.pop_front();
        total++;
        if (bif.buf_rvalid !== 1'b1 || bif.buf_rdata !== e) begin
          bad++; $display("FAIL rbw got=%b/%0h want=1/%0h", bif.buf_rvalid, bif.buf_rdata, e);
        end
        tick();
      end else begin
        send_byte(8'(i * 13 + 200), 1'b1);
      end
    end
    total++;
    if (bif.avail !== 1'b1) begin bad++; $display("FAIL refill_avail got=%b want=1", bif.avail); end
    read_check(9'd0);
    read_check(9'd10);
    read_check(9'd199);
    read_check(9'd200);
    read_check(9'd511);
  endtask

  task automatic test_timeout();
    int k;
    tif.sd_ready = 1;
    tif.cmd_addr = 32'h5; tif.cmd_addr_we = 1; tif.cmd_start = 1;
    tick();
    tif.cmd_addr_we = 0; tif.cmd_start = 0;
    tick();
    tif.sd_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tif.sd_dout = 8'(i + 1); tif.sd_byte_available = 1;
      tick();
      tif.sd_byte_available = 0;
      if (i < 2) tick();
    end
    k = 0;
    while (k < 200) begin
      tick(); k++;
      if (tif.busy === 1'b0) break;
    end
    total++;
    if (k != 64) begin bad++; $display("FAIL fill_tmo_cycles got=%0d want=64", k); end
    total++;
    if (tif.timeout !== 1'b1 || tif.avail !== 1'b0 || tif.state_dbg !== ST_IDLE) begin
      bad++; $display("FAIL fill_tmo_flags got=%b/%b/%0d want=1/0/%0d",
                      tif.timeout, tif.avail, tif.state_dbg, ST_IDLE);
    end
    tif.cmd_start = 1;
    tick();
    tif.cmd_start = 0;
    total++;
    if (tif.timeout !== 1'b0 || tif.busy !== 1'b1) begin
      bad++; $display("FAIL tmo_clear got=%b/%b want=0/1", tif.timeout, tif.busy);
    end
    k = 0;
    while (k < 200) begin
      tick(); k++;
      if (tif.busy === 1'b0) break;
    end
    total++;
    if (k != 64 || tif.timeout !== 1'b1 || tif.sd_rd !== 1'b0) begin
      bad++; $display("FAIL wait_tmo got=%0d/%b want=64/1", k, tif.timeout);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_fill();
    test_ready_wait();
    test_ignore_busy();
    test_level_hold();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
